// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM bus between timer_ctrl_master and the interval timer slave
// (3-bit word address, 16-bit data, no waitrequest, level interrupt).
interface timer_ctrl_master_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs the interval timer and services each timeout.
// Define TIMER_MASTER_SNAPSHOT_EN to capture a counter snapshot after every clear.
module timer_ctrl_master (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_start,
  input  logic                       cfg_stop,
  input  logic [31:0]                cfg_period,
  input  logic                       cfg_continuous,
  timer_ctrl_master_if.master        bus,
  output logic                       busy,
  output logic                       tick,
  output logic [31:0]                tick_count,
  output logic [31:0]                snapshot,
  output logic                       snap_valid
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR,
    SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DN, WR_STOP
  } state_t;

  state_t      state_reg, state_next, post_state;
  logic [31:0] period_reg;
  logic        continuous_reg;
  logic        stop_pending_reg;
  logic [31:0] tick_count_reg;

  logic [2:0]  address_next;
  logic        chipselect_next;
  logic        write_n_next;
  logic [15:0] writedata_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      period_reg       <= '0;
      continuous_reg   <= 1'b0;
      stop_pending_reg <= 1'b0;
      tick_count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && cfg_start) begin
        period_reg     <= cfg_period;
        continuous_reg <= cfg_continuous;
        tick_count_reg <= '0;
      end else if (state_reg == CLR) begin
        tick_count_reg <= tick_count_reg + 32'd1;
      end
      if (state_next == IDLE)
        stop_pending_reg <= 1'b0;
      else if (cfg_stop && state_reg != IDLE)
        stop_pending_reg <= 1'b1;
    end
  end

  // Zero-time decision taken once a timeout has been fully serviced.
  always_comb begin
    if (stop_pending_reg)
      post_state = WR_STOP;
    else if (continuous_reg)
      post_state = RUN;
    else
      post_state = IDLE;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cfg_start) state_next = WR_PL;
      WR_PL:   state_next = WR_PH;
      WR_PH:   state_next = WR_CTL;
      WR_CTL:  state_next = RUN;
      // A pending timeout is serviced before any deferred stop.
      RUN: begin
        if (bus.irq)
          state_next = CLR;
        else if (stop_pending_reg)
          state_next = WR_STOP;
      end
`ifdef TIMER_MASTER_SNAPSHOT_EN
      CLR:     state_next = SNAP_WR;
      SNAP_WR: state_next = SNAP_RL;
      SNAP_RL: state_next = SNAP_RH;
      SNAP_RH: state_next = SNAP_DN;
      SNAP_DN: state_next = post_state;
`else
      CLR:     state_next = post_state;
`endif
      WR_STOP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    address_next    = 3'd0;
    chipselect_next = 1'b0;
    write_n_next    = 1'b1;
    writedata_next  = 16'h0000;
    tick            = 1'b0;
    case (state_reg)
      WR_PL: begin
        chipselect_next = 1'b1; write_n_next = 1'b0;
        address_next = 3'd2; writedata_next = period_reg[15:0];
      end
      WR_PH: begin
        chipselect_next = 1'b1; write_n_next = 1'b0;
        address_next = 3'd3; writedata_next = period_reg[31:16];
      end
      WR_CTL: begin
        chipselect_next = 1'b1; write_n_next = 1'b0;
        address_next = 3'd1;
        writedata_next = continuous_reg ? 16'h0007 : 16'h0005;
      end
      CLR: begin
        chipselect_next = 1'b1; write_n_next = 1'b0;
        address_next = 3'd0; tick = 1'b1;
      end
      SNAP_WR: begin
        chipselect_next = 1'b1; write_n_next = 1'b0;
        address_next = 3'd4;
      end
      SNAP_RL: begin
        chipselect_next = 1'b1; address_next = 3'd4;
      end
      SNAP_RH: begin
        chipselect_next = 1'b1; address_next = 3'd5;
      end
      WR_STOP: begin
        chipselect_next = 1'b1; write_n_next = 1'b0;
        address_next = 3'd1; writedata_next = 16'h0008;
      end
      default: ;
    endcase
  end

  assign bus.address    = address_next;
  assign bus.chipselect = chipselect_next;
  assign bus.write_n    = write_n_next;
  assign bus.writedata  = writedata_next;
  assign busy           = (state_reg != IDLE);
  assign tick_count     = tick_count_reg;

`ifdef TIMER_MASTER_SNAPSHOT_EN
  logic [15:0] snap_lo_reg;
  logic [31:0] snapshot_reg;
  logic        snap_valid_reg;

  // readdata lags the address by one cycle; both halves land together so the
  // published snapshot never shows a half-updated value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo_reg    <= '0;
      snapshot_reg   <= '0;
      snap_valid_reg <= 1'b0;
    end else begin
      snap_valid_reg <= (state_reg == SNAP_DN);
      if (state_reg == SNAP_RH)
        snap_lo_reg <= bus.readdata;
      if (state_reg == SNAP_DN)
        snapshot_reg <= {bus.readdata, snap_lo_reg};
    end
  end

  assign snapshot   = snapshot_reg;
  assign snap_valid = snap_valid_reg;
`else
  assign snapshot   = 32'h0000_0000;
  assign snap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Randomized self-checking bench for timer_ctrl_master: a behavioural timer
// slave plus an expected-write queue built from the programming rules.
module tb_timer_ctrl_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [31:0] cfg_period = '0;
  logic        cfg_continuous = 1'b0;
  logic        busy, tick, snap_valid;
  logic [31:0] tick_count, snapshot;

  timer_ctrl_master_if bus ();

  timer_ctrl_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .bus            (bus),
    .busy           (busy),
    .tick           (tick),
    .tick_count     (tick_count),
    .snapshot       (snapshot),
    .snap_valid     (snap_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Timer slave: level irq raised on request, dropped by a status clear write;
  // registered readdata returns the snapshot halves at words 4 and 5.
  logic        irq_fire = 1'b0;
  logic [15:0] snap_lo = 16'h2345;
  logic [15:0] snap_hi = 16'h0001;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.irq      <= 1'b0;
      bus.readdata <= 16'h0000;
    end else begin
      if (bus.chipselect && !bus.write_n && bus.address == 3'd0)
        bus.irq <= 1'b0;
      else if (irq_fire)
        bus.irq <= 1'b1;
      if (bus.chipselect && bus.write_n)
        bus.readdata <= (bus.address == 3'd4) ? snap_lo :
                        (bus.address == 3'd5) ? snap_hi : 16'h0000;
    end
  end

  // Reference model: the ordered list of writes the master must issue.
  logic [18:0] exp_q[$];
  logic [18:0] mon_exp;
  int          spurious = 0;
  int unsigned model_count = 0;
  bit          model_cont = 1'b0;

  always @(negedge clk) begin
    if (reset_n && bus.chipselect && !bus.write_n) begin
      $display("bus write addr=%0d data=0x%04h t=%0t", bus.address, bus.writedata, $time);
      if (exp_q.size() == 0) begin
        spurious++;
      end else begin
        mon_exp = exp_q.pop_front();
        check("bus_write", {13'd0, bus.address, bus.writedata}, {13'd0, mon_exp});
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 12 && busy; i++) step();
    check(tag, busy, 1'b0);
    check({tag, "_bus"}, bus.chipselect, 1'b0);
  endtask

  task automatic start_timer(input logic [31:0] p, input bit c);
    exp_q.push_back({3'd2, p[15:0]});
    exp_q.push_back({3'd3, p[31:16]});
    exp_q.push_back({3'd1, c ? 16'h0007 : 16'h0005});
    cfg_start = 1'b1; cfg_period = p; cfg_continuous = c;
    step();
    cfg_start = 1'b0; cfg_period = $urandom; cfg_continuous = ~c;
    model_count = 0; model_cont = c;
    check("busy_rise", busy, 1'b1);
    check("wr_pl_cycle", {bus.chipselect, bus.write_n, bus.address}, {1'b1, 1'b0, 3'd2});
    step();
    check("wr_ph_cycle", {bus.chipselect, bus.write_n, bus.address}, {1'b1, 1'b0, 3'd3});
    step();
    check("wr_ctl_cycle", {bus.chipselect, bus.write_n, bus.address}, {1'b1, 1'b0, 3'd1});
    step();
    check("run_bus_idle", bus.chipselect, 1'b0);
    check("count_cleared", tick_count, 32'd0);
    $display("start period=0x%08h continuous=%0d", p, c);
  endtask

  // Raise one timeout; optionally issue cfg_stop on the same sampling edge.
  task automatic service(input bit with_stop);
    int waited = 0;
    bit found = 1'b0;
    exp_q.push_back({3'd0, 16'h0000});
`ifdef TIMER_MASTER_SNAPSHOT_EN
    exp_q.push_back({3'd4, 16'h0000});
`endif
    if (with_stop) exp_q.push_back({3'd1, 16'h0008});
    irq_fire = 1'b1;
    step();
    irq_fire = 1'b0;
    if (with_stop) cfg_stop = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      cfg_stop = 1'b0;
      waited++;
      if (tick) found = 1'b1;
    end
    check("tick_seen", found, 1'b1);
    check("irq_latency", waited, 1);
    model_count++;
    step();
    check("tick_one_cycle", tick, 1'b0);
    check("tick_count", tick_count, model_count);
`ifdef TIMER_MASTER_SNAPSHOT_EN
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (snap_valid) found = 1'b1;
      else step();
    end
    check("snap_valid_seen", found, 1'b1);
    check("snapshot", snapshot, {snap_hi, snap_lo});
    step();
    check("snap_valid_pulse", snap_valid, 1'b0);
    snap_lo = 16'($urandom);
    snap_hi = 16'($urandom);
`endif
    $display("service tick_count=%0d stop=%0d", model_count, with_stop);
    if (with_stop || !model_cont) wait_idle("idle_after_service");
  endtask

  task automatic stop_timer();
    exp_q.push_back({3'd1, 16'h0008});
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    wait_idle("idle_after_stop");
    check("count_after_stop", tick_count, model_count);
    $display("stop tick_count=%0d", model_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    bit c;
    int n;

    step(3);
    check("reset_bus", {bus.chipselect, bus.write_n, bus.address}, {1'b0, 1'b1, 3'd0});
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_bus", {bus.chipselect, bus.write_n, bus.address}, {1'b0, 1'b1, 3'd0});
      check("idle_wdata", bus.writedata, 16'h0000);
      check("idle_flags", {busy, tick, snap_valid}, 3'b000);
      check("idle_count", tick_count, 32'd0);
      check("idle_snapshot", snapshot, 32'd0);
    end

    // One-shot with a period spanning both halves.
    start_timer(32'h0001_86A0, 1'b0);
    step(4);
    service(1'b0);
    check("oneshot_count", tick_count, 32'd1);

    // Stop while idle must not touch the bus.
    cfg_stop = 1'b1; step(); cfg_stop = 1'b0; step(3);
    check("stop_in_idle", busy, 1'b0);

    // Continuous, five timeouts, a start attempt while busy, then stop.
    start_timer(32'd99, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step($urandom_range(0, 4));
      service(1'b0);
    end
    check("cont_busy", busy, 1'b1);
    check("cont_count", tick_count, 32'd5);
    cfg_start = 1'b1; cfg_period = 32'hDEAD_BEEF; step(); cfg_start = 1'b0; step(3);
    check("start_while_busy", tick_count, 32'd5);
    stop_timer();

    // irq and stop sampled on the same edge: clear first, then stop.
    start_timer($urandom, 1'b1);
    service(1'b0);
    step(2);
    service(1'b1);
    check("irq_stop_count", tick_count, 32'd2);

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      p = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      c = 1'($urandom_range(0, 1));
      start_timer(p, c);
      n = c ? $urandom_range(1, 4) : 1;
      for (int i = 0; i < n; i++) begin
        step($urandom_range(0, 6));
        service(c && (i == n - 1) && ($urandom_range(0, 1) == 1));
      end
      if (busy) begin
        step($urandom_range(0, 5));
        stop_timer();
      end
      step($urandom_range(1, 4));
    end

    // Reset in the middle of the period writes.
    exp_q.push_back({3'd2, 16'h5678});
    exp_q.push_back({3'd3, 16'h1234});
    exp_q.push_back({3'd1, 16'h0005});
    cfg_start = 1'b1; cfg_period = 32'h1234_5678; cfg_continuous = 1'b0;
    step();
    cfg_start = 1'b0;
    step();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_bus_idle", {bus.chipselect, bus.write_n}, 2'b01);
    check("rst_busy", busy, 1'b0);
    check("rst_count", tick_count, 32'd0);
    exp_q.delete();
    step(2);
    reset_n = 1'b1;
    step(2);
    start_timer(32'h0000_0010, 1'b0);
    service(1'b0);

    step(4);
    check("pending_writes", exp_q.size(), 0);
    check("spurious_writes", spurious, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_ctrl_master.md
# timer_ctrl_master

Avalon-MM master that programs and services the 16-bit-data interval timer slave (3-bit word address, no waitrequest, registered readdata). On a start request it loads a 32-bit period, starts the timer with interrupt enabled, then services every timeout: it clears the status flag, counts ticks and optionally captures a counter snapshot. It sits between fabric control logic and the timer slave, replacing software servicing of the timer.

## Interface
- No parameters.
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  pulse; start request, honoured only in IDLE
- cfg_stop  in  1  pulse; stop request, honoured while busy
- cfg_period  in  32  timer period; sampled into a holding register on accepted cfg_start
- cfg_continuous  in  1  sampled with cfg_period; 1 = continuous, 0 = one-shot
- address  out  3  timer word address
- chipselect  out  1  bus select
- write_n  out  1  active-low write
- writedata  out  16  write data
- readdata  in  16  timer read data; valid the cycle after address is presented
- irq  in  1  timer interrupt, level
- busy  out  1  high from first bus cycle until return to IDLE
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  32  serviced timeouts since last accepted start
- snapshot  out  32  last captured counter value (macro only; else 0)
- snap_valid  out  1  one-cycle pulse when snapshot updates (macro only; else 0)

## Operation
- All outputs registered/Moore-decoded from state; reset values: address 0, chipselect 0, write_n 1, writedata 0, busy 0, tick 0, tick_count 0, snapshot 0, snap_valid 0; state IDLE, stop_pending 0.
- States and bus cycle driven (each one cycle, chipselect 1):
  - IDLE: bus idle (chipselect 0, write_n 1). cfg_start -> WR_PL; holding regs loaded, tick_count cleared.
  - WR_PL: write addr 2, data period[15:0] -> WR_PH.
  - WR_PH: write addr 3, data period[31:16] -> WR_CTL.
  - WR_CTL: write addr 1, data 0x0005 (start|ito), or 0x0007 if continuous -> RUN.
  - RUN: bus idle. irq=1 -> CLR; else stop_pending -> WR_STOP.
  - CLR: write addr 0, data 0; tick=1; tick_count+1 at exit edge. Next: SNAP_WR if macro, else POST.
  - POST (decision, no bus cycle, zero-time): stop_pending -> WR_STOP; one-shot -> IDLE; continuous -> RUN.
  - WR_STOP: write addr 1, data 0x0008 -> IDLE.
- irq has priority over stop in RUN; stop is deferred until after servicing.
- stop_pending set by cfg_stop while busy, cleared on entering IDLE; cfg_stop in IDLE ignored; cfg_start while busy ignored.
- tick_count wraps 0xFFFFFFFF -> 0.
- cfg_period 0 passed through unchanged (no clamping).
- Reset mid-operation: all state returns to reset values immediately; timer slave is reset by the same reset_n.

## Timing
- Start accepted at edge k: WR_PL in cycle k+1, WR_PH k+2, WR_CTL k+3, RUN from k+4; busy rises at k+1.
- irq sampled high at edge j in RUN: CLR write in cycle j+1; slave flag clears at edge ending j+1, so irq is low when RUN resumes (earliest RUN resample at edge j+2 without macro).
- Service latency irq->clear write: 1 cycle (no macro), 4 extra cycles with snapshot.
- Timeout coinciding with the CLR write is lost (slave gives clear priority); requires period >= 8 cycles for lossless continuous service.
- busy falls the cycle after the last write (WR_STOP, or CLR/snapshot in one-shot).

## Configuration
- TIMER_MASTER_SNAPSHOT_EN defined: after CLR, SNAP_WR (write addr 4, data 0) -> SNAP_RL (read addr 4) -> SNAP_RH (read addr 5, capture readdata as low half) -> SNAP_DN (bus idle, capture readdata as high half, snap_valid=1) -> POST.
- Undefined: snapshot states absent, snapshot and snap_valid tied 0, CLR goes directly to POST.

## Test plan
- Reset: all outputs at reset values, bus idle for 10 cycles with irq=0.
- One-shot start, cfg_period=0x0001_86A0: writes addr2=0x86A0, addr3=0x0001, addr1=0x0005 on consecutive cycles; after irq, one write addr0=0x0000, tick once, tick_count=1, busy low.
- Continuous, period 99, run 5 timeouts: control write 0x0007, five clear writes, tick_count=5, stays busy; cfg_stop -> write addr1=0x0008, IDLE.
- irq and cfg_stop same cycle in RUN: clear write first, tick_count+1, then stop write, IDLE.
- Macro on, slave counter snapshot 0x0001_2345: reads at addr4 then addr5, snapshot=0x00012345, snap_valid one pulse.
- reset_n asserted during WR_PH: bus idle immediately, busy 0; subsequent start performs full 3-write sequence.
